// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD engine.
//   state_t       controller state encoding (S_IDLE, S_RUN, S_DONE)
//   GCD_WIDTH     default operand/result width
//   GCD_CNT_WIDTH default iteration counter width
package gcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int GCD_WIDTH     = 4;
    localparam int GCD_CNT_WIDTH = 4;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers A/B, their comparison and a single
// larger-minus-smaller subtractor for subtractive Euclid.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   load              capture a_in/b_in into A/B
//   sub_a / sub_b     replace A (or B) with the difference
//   a_in, b_in        operands to capture
//   a, b              current operand register values
//   eq, a_gt_b        comparison flags of the current operands
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             sub_a,
    input  logic             sub_b,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             a_gt_b
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] bit_eq;
    logic [WIDTH-1:0] diff;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_eq
            assign bit_eq[gi] = ~(a_reg[gi] ^ b_reg[gi]);
        end
    endgenerate

    assign eq     = &bit_eq;
    assign a_gt_b = (a_reg > b_reg);
    // One shared subtractor; operand order chosen so it never underflows.
    assign diff   = a_gt_b ? (a_reg - b_reg) : (b_reg - a_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (load) begin
            a_reg <= a_in;
            b_reg <= b_in;
        end else if (sub_a) begin
            a_reg <= diff;
        end else if (sub_b) begin
            b_reg <= diff;
        end
    end

    assign a = a_reg;
    assign b = b_reg;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: start/done controller for subtractive-Euclid GCD.
// One GCD per accepted start; result and iter hold until the next run.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          request, only honoured while ready
//   abort          cancels a running computation (RUN only)
//   a_in, b_in     operands, captured on the accepting edge
//   ready          idle, start will be accepted
//   busy           computation in progress
//   done           one-cycle completion pulse
//   result         GCD of the last completed run
//   iter           subtraction steps of the last/ongoing run (saturating)
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH     = GCD_WIDTH,
    parameter int CNT_WIDTH = GCD_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [CNT_WIDTH-1:0] iter
);

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic [CNT_WIDTH-1:0] iter_reg, iter_next;
    logic                 load, sub_a, sub_b;
    logic [WIDTH-1:0]     a_val, b_val;
    logic                 eq, a_gt_b;

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .sub_a   (sub_a),
        .sub_b   (sub_b),
        .a_in    (a_in),
        .b_in    (b_in),
        .a       (a_val),
        .b       (b_val),
        .eq      (eq),
        .a_gt_b  (a_gt_b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            result_reg <= '0;
            iter_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            iter_reg   <= iter_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        iter_next   = iter_reg;
        load        = 1'b0;
        sub_a       = 1'b0;
        sub_b       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    iter_next = '0;
                    // A zero operand needs no iteration: gcd(0,x) = x.
                    if (a_in == '0 || b_in == '0) begin
                        result_next = a_in | b_in;
                        state_next  = S_DONE;
                    end else begin
                        state_next  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // abort wins over a completion in the same cycle.
                if (abort) begin
                    state_next = S_IDLE;
                end else if (eq) begin
                    result_next = a_val;
                    state_next  = S_DONE;
                end else begin
                    sub_a     = a_gt_b;
                    sub_b     = ~a_gt_b;
                    iter_next = (iter_reg == '1) ? iter_reg : iter_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ready  = (state_reg == S_IDLE);
    assign busy   = (state_reg == S_RUN);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;
    assign iter   = iter_reg;

endmodule

// File: tb/tb_gcd_engine.sv
module tb_gcd_engine;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [3:0] iter;

    int n_cmp = 0;
    int n_bad = 0;

    gcd_engine #(.WIDTH(4), .CNT_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .a_in    (a_in),
        .b_in    (b_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .iter    (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int res;
        int it;
        int lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by division. Subtractive Euclid performs
    // (sum of quotients - 1) subtractions before the operands meet.
    function automatic void model(input int a, input int b,
                                  output int g, output int n, output int lat);
        int x, y, t, s;
        if (a == 0 || b == 0) begin
            g = a | b; n = 0; lat = 0;
        end else begin
            x = a; y = b; s = 0;
            while (y != 0) begin
                s += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = x;
            n = s - 1;
            lat = n + 1;
            if (n > 15) n = 15;
        end
    endfunction

    // Issue one start and wait for done; checks result, iter, latency and
    // that done is a single-cycle pulse.
    task automatic run_gcd(input string tag, input int a, input int b,
                           input int exp_res, input int exp_it, input int exp_lat);
        int cnt;
        @(negedge clk);
        start = 1'b1;
        a_in  = a[3:0];
        b_in  = b[3:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, " done_seen"}, int'(done), 1);
        check({tag, " latency"}, cnt, exp_lat);
        check({tag, " result"}, int'(result), exp_res);
        check({tag, " iter"}, int'(iter), exp_it);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, int'(done), 0);
        check({tag, " ready_after"}, int'(ready), 1);
        $display("run %s a=%0d b=%0d result=%0d iter=%0d lat=%0d", tag, a, b,
                 result, iter, cnt);
    endtask

    vec_t vecs[8];

    initial begin
        int g, n, lat, prev;
        int ra, rb;
        bit seen_done;

        vecs[0] = '{12, 8, 4, 2, 3};
        vecs[1] = '{15, 1, 1, 14, 15};
        vecs[2] = '{0, 9, 9, 0, 0};
        vecs[3] = '{0, 0, 0, 0, 0};
        vecs[4] = '{5, 5, 5, 0, 1};
        vecs[5] = '{9, 6, 3, 2, 3};
        vecs[6] = '{7, 0, 7, 0, 0};
        vecs[7] = '{14, 10, 2, 4, 5};

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", int'(ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset result", int'(result), 0);
        check("reset iter", int'(iter), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_gcd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].it, vecs[i].lat);
        end

        // Reset in the middle of a (15,1) run: no done, everything cleared
        @(negedge clk);
        start = 1'b1; a_in = 4'd15; b_in = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen_done = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("midrun busy_before_reset", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_reset ready", int'(ready), 1);
        check("midrun_reset busy", int'(busy), 0);
        check("midrun_reset result", int'(result), 0);
        check("midrun_reset iter", int'(iter), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("midrun_reset no_done", int'(seen_done), 0);
        $display("seq midrun_reset ready=%0d result=%0d", ready, result);

        // start held through RUN and DONE with other operands: ignored
        @(negedge clk);
        start = 1'b1; a_in = 4'd5; b_in = 4'd5;
        @(posedge clk);
        #1;
        a_in = 4'd3; b_in = 4'd6;
        check("hold busy", int'(busy), 1);
        @(posedge clk);
        #1;
        check("hold done", int'(done), 1);
        check("hold result", int'(result), 5);
        check("hold iter", int'(iter), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold ready", int'(ready), 1);
        check("hold result_kept", int'(result), 5);
        $display("seq start_ignored result=%0d", result);
        run_gcd("resample", 3, 6, 3, 1, 2);

        // Abort after 4 RUN cycles of (15,1)
        prev = int'(result);
        @(negedge clk);
        start = 1'b1; a_in = 4'd15; b_in = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort ready", int'(ready), 1);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort result", int'(result), prev);
        $display("seq abort result=%0d", result);
        run_gcd("after_abort", 9, 6, 3, 2, 3);

        // Abort coincident with a==b completion: abort wins
        prev = int'(result);
        @(negedge clk);
        start = 1'b1; a_in = 4'd7; b_in = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_eq done", int'(done), 0);
        check("abort_eq ready", int'(ready), 1);
        check("abort_eq result", int'(result), prev);
        $display("seq abort_eq result=%0d", result);

        // Abort in DONE is ignored
        @(negedge clk);
        start = 1'b1; a_in = 4'd0; b_in = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b1;
        check("abort_done done", int'(done), 1);
        check("abort_done result", int'(result), 4);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_done ready", int'(ready), 1);
        $display("seq abort_in_done result=%0d", result);

        // Randomized runs against the reference model
        for (int i = 0; i < 150; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            model(ra, rb, g, n, lat);
            run_gcd($sformatf("rnd%0d", i), ra, rb, g, n, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
